// File: rtl/key_expansion.sv
// Iterative AES-128 key schedule: captures four key words, then expands them into
// the 44-word round-key schedule at one word per clock, with a combinational read port.
module key_expansion (
  input  logic        clock,
  input  logic        reset,
  input  logic        key_start,
  input  logic [31:0] key_word_in,
  input  logic [3:0]  rk_round,
  input  logic [1:0]  rk_col,
  output logic [31:0] rk_word,
  output logic        key_expand_done,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    EXPAND = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Forward S-box, byte 0x00 in the most significant position.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [11:0] pos;
    pos  = 12'd2047 - {1'b0, b, 3'b000};
    sbox = SBOX_TABLE[pos -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    sub_word = {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    rot_word = {w[23:0], w[31:24]};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  state_t      state_r, state_next_s;
  logic [5:0]  idx_r, idx_next_s;
  logic [31:0] w_r [0:43];
  logic        done_r, busy_r;
  logic        wr_en_s;
  logic [31:0] wr_data_s;
  logic [31:0] prev_word_s, back4_word_s, temp_word_s, expand_word_s;
  logic [5:0]  rd_idx_s;

  // Next schedule word from w[idx-1] and w[idx-4]; guarded so reads stay in range.
  always_comb begin
    prev_word_s  = 32'h0000_0000;
    back4_word_s = 32'h0000_0000;
    temp_word_s  = 32'h0000_0000;
    if ((idx_r >= 6'd4) && (idx_r <= 6'd43)) begin
      prev_word_s  = w_r[idx_r - 6'd1];
      back4_word_s = w_r[idx_r - 6'd4];
    end else begin
      prev_word_s  = 32'h0000_0000;
      back4_word_s = 32'h0000_0000;
    end
    if (idx_r[1:0] == 2'b00) begin
      temp_word_s = sub_word(rot_word(prev_word_s)) ^ {rcon(idx_r[5:2]), 24'h00_0000};
    end else begin
      temp_word_s = prev_word_s;
    end
    expand_word_s = back4_word_s ^ temp_word_s;
  end

  // Next-state, counter and write-enable decode; a start request overrides everything.
  always_comb begin
    state_next_s = state_r;
    idx_next_s   = idx_r;
    wr_en_s      = 1'b0;
    wr_data_s    = 32'h0000_0000;
    if (key_start) begin
      state_next_s = LOAD;
      idx_next_s   = 6'd0;
    end else begin
      case (state_r)
        IDLE: begin
          state_next_s = IDLE;
        end
        LOAD: begin
          wr_en_s    = 1'b1;
          wr_data_s  = key_word_in;
          idx_next_s = idx_r + 6'd1;
          if (idx_r == 6'd3) begin
            state_next_s = EXPAND;
          end else begin
            state_next_s = LOAD;
          end
        end
        EXPAND: begin
          wr_en_s    = 1'b1;
          wr_data_s  = expand_word_s;
          idx_next_s = idx_r + 6'd1;
          if (idx_r == 6'd43) begin
            state_next_s = DONE;
          end else begin
            state_next_s = EXPAND;
          end
        end
        DONE: begin
          state_next_s = DONE;
        end
        default: begin
          state_next_s = IDLE;
          idx_next_s   = 6'd0;
        end
      endcase
    end
  end

  // Control registers; done and busy are registered from the next state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      idx_r   <= 6'd0;
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      idx_r   <= idx_next_s;
      done_r  <= (state_next_s == DONE);
      busy_r  <= (state_next_s == LOAD) || (state_next_s == EXPAND);
    end
  end

  // Round-key word storage; cleared on reset so no partial schedule survives.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 44; i++) begin
        w_r[i] <= 32'h0000_0000;
      end
    end else if (wr_en_s) begin
      w_r[idx_r] <= wr_data_s;
    end
  end

  // Read port: {round, col} is exactly 4*round + col.
  always_comb begin
    rd_idx_s = {rk_round, rk_col};
    if (rk_round > 4'd10) begin
      rk_word = 32'h0000_0000;
    end else begin
      rk_word = w_r[rd_idx_s];
    end
  end

  assign key_expand_done = done_r;
  assign busy            = busy_r;
  assign dbg_state       = state_r;

endmodule

// File: tb/tb_key_expansion.sv
// Directed bench for key_expansion: FIPS-197 and all-zero key schedules, restart,
// asynchronous reset, done hold and start/final-edge collision.
module tb_key_expansion;

  logic        clock;
  logic        reset;
  logic        key_start;
  logic [31:0] key_word_in;
  logic [3:0]  rk_round;
  logic [1:0]  rk_col;
  logic [31:0] rk_word;
  logic        key_expand_done;
  logic        busy;
  logic [1:0]  dbg_state;

  int checks;
  int errors;
  int edge_cnt;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
  localparam logic [127:0] ZERO_KEY = 128'h0;

  key_expansion dut (
    .clock           (clock),
    .reset           (reset),
    .key_start       (key_start),
    .key_word_in     (key_word_in),
    .rk_round        (rk_round),
    .rk_col          (rk_col),
    .rk_word         (rk_word),
    .key_expand_done (key_expand_done),
    .busy            (busy),
    .dbg_state       (dbg_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clock);
    key_start = 1'b1;
    @(posedge clock);
    edge_cnt = 0;
  endtask

  task automatic feed(input logic [127:0] k);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      key_start   = 1'b0;
      key_word_in = k[127 - 32*i -: 32];
      @(posedge clock);
      edge_cnt++;
    end
  endtask

  task automatic wait_done();
    while (edge_cnt < 80) begin
      @(negedge clock);
      if (key_expand_done) break;
      @(posedge clock);
      edge_cnt++;
    end
    chk("latency", edge_cnt, 32'd44);
  endtask

  task automatic rd(input string tag, input logic [3:0] r, input logic [1:0] c,
                    input logic [31:0] exp);
    rk_round = r;
    rk_col   = c;
    #1;
    chk(tag, rk_word, exp);
  endtask

  task automatic check_fips();
    rd("fips_r1c0", 4'd1, 2'd0, 32'ha0fafe17);
    rd("fips_r1c1", 4'd1, 2'd1, 32'h88542cb1);
    rd("fips_r1c2", 4'd1, 2'd2, 32'h23a33939);
    rd("fips_r1c3", 4'd1, 2'd3, 32'h2a6c7605);
    rd("fips_r10c0", 4'd10, 2'd0, 32'hd014f9a8);
    rd("fips_r10c1", 4'd10, 2'd1, 32'hc9ee2589);
    rd("fips_r10c2", 4'd10, 2'd2, 32'he13f0cc8);
    rd("fips_r10c3", 4'd10, 2'd3, 32'hb6630ca6);
    rd("fips_r0c0", 4'd0, 2'd0, 32'h2b7e1516);
    rd("fips_r0c3", 4'd0, 2'd3, 32'h09cf4f3c);
  endtask

  task automatic check_zero();
    rd("zero_w4", 4'd1, 2'd0, 32'h62636363);
    rd("zero_r10c0", 4'd10, 2'd0, 32'hb4ef5bcb);
    rd("zero_r10c1", 4'd10, 2'd1, 32'h3e92e211);
    rd("zero_r10c2", 4'd10, 2'd2, 32'h23e951cf);
    rd("zero_r10c3", 4'd10, 2'd3, 32'h6f8f188e);
    rd("zero_r11", 4'd11, 2'd0, 32'h00000000);
    rd("zero_r15", 4'd15, 2'd3, 32'h00000000);
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    edge_cnt    = 0;
    reset       = 1'b1;
    key_start   = 1'b0;
    key_word_in = 32'h0;
    rk_round    = 4'd0;
    rk_col      = 2'd0;

    // Reset state
    #12;
    chk("rst_done", {31'd0, key_expand_done}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_state", {30'd0, dbg_state}, 32'd0);
    chk("rst_rk", rk_word, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // FIPS-197 key load and readback
    pulse_start();
    #1;
    chk("start_busy", {31'd0, busy}, 32'd1);
    chk("start_state", {30'd0, dbg_state}, 32'd1);
    feed(FIPS_KEY);
    wait_done();
    check_fips();

    // Done hold for 100 idle clocks, then a start drops done on the next edge
    repeat (100) @(posedge clock);
    @(negedge clock);
    chk("hold_done", {31'd0, key_expand_done}, 32'd1);
    chk("hold_state", {30'd0, dbg_state}, 32'd3);
    chk("hold_busy", {31'd0, busy}, 32'd0);
    rd("hold_r10c0", 4'd10, 2'd0, 32'hd014f9a8);
    rd("hold_r1c3", 4'd1, 2'd3, 32'h2a6c7605);
    pulse_start();
    #1;
    chk("restart_done_drop", {31'd0, key_expand_done}, 32'd0);

    // All-zero key
    feed(ZERO_KEY);
    wait_done();
    check_zero();

    // Restart mid-expansion with the zero key after a partial FIPS expansion
    pulse_start();
    feed(FIPS_KEY);
    repeat (16) @(posedge clock);
    @(negedge clock);
    chk("mid_state", {30'd0, dbg_state}, 32'd2);
    pulse_start();
    #1;
    chk("mid_restart_done", {31'd0, key_expand_done}, 32'd0);
    feed(ZERO_KEY);
    wait_done();
    check_zero();

    // Asynchronous reset during LOAD, between clock edges
    pulse_start();
    feed(FIPS_KEY);
    pulse_start();
    @(negedge clock);
    key_start   = 1'b0;
    key_word_in = 32'h2b7e1516;
    @(posedge clock);
    @(negedge clock);
    rd("pre_reset_w0", 4'd0, 2'd0, 32'h2b7e1516);
    #1;
    reset = 1'b1;
    #1;
    chk("areset_busy", {31'd0, busy}, 32'd0);
    chk("areset_state", {30'd0, dbg_state}, 32'd0);
    chk("areset_rk", rk_word, 32'd0);
    #1;
    reset = 1'b0;
    pulse_start();
    feed(FIPS_KEY);
    wait_done();
    check_fips();

    // Start collides with the final expansion edge; start held for extra cycles
    pulse_start();
    feed(ZERO_KEY);
    repeat (39) @(posedge clock);
    @(negedge clock);
    key_start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk("collide_done", {31'd0, key_expand_done}, 32'd0);
    chk("collide_state", {30'd0, dbg_state}, 32'd1);
    key_word_in = 32'hdeadbeef;
    @(posedge clock);
    @(negedge clock);
    key_word_in = 32'hcafef00d;
    @(posedge clock);
    edge_cnt = 0;
    feed(FIPS_KEY);
    wait_done();
    check_fips();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
